// File: rtl/readout_pkg.sv
// Shared types and constants for the readout token scheduler.
package readout_pkg;
  localparam int N_CHAIN_DEF = 17;
  localparam int CHAIN_IDX_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_GRANT,
    S_GAP
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr, wrapping.
module rr_arbiter
  import readout_pkg::*;
#(
  parameter int N = N_CHAIN_DEF
) (
  input  logic [N-1:0]           req,
  input  logic [CHAIN_IDX_W-1:0] ptr,
  output logic                   found,
  output logic [CHAIN_IDX_W-1:0] idx
);

  logic [N-1:0] hi;
  logic [N-1:0] req_hi;

  // Prefer bits above ptr; fall back to lowest set bit (the wrap).
  always_comb begin
    hi    = '0;
    found = |req;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      hi[k] = (CHAIN_IDX_W'(k) > ptr);
    end
    req_hi = req & hi;
    if (|req_hi) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_hi[k]) idx = CHAIN_IDX_W'(k);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[k]) idx = CHAIN_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/readout_token_scheduler.sv
// Grants one readout token at a time to host/auto-scan requested chains,
// round-robin, with a watchdog that aborts and flags stuck chains.
module readout_token_scheduler
  import readout_pkg::*;
#(
  parameter int N_CHAIN   = N_CHAIN_DEF,
  parameter int PERIOD_W  = 33,
  parameter int TIMEOUT_W = 24
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   auto_en_i,
  input  logic [PERIOD_W-1:0]    period_i,
  input  logic [N_CHAIN-1:0]     chain_mask_i,
  input  logic [TIMEOUT_W-1:0]   timeout_i,
  input  logic [N_CHAIN-1:0]     host_req_i,
  input  logic [N_CHAIN-1:0]     token_ready_i,
  input  logic                   flag_clr_i,
  output logic [N_CHAIN-1:0]     token_valid_o,
  output logic                   busy_o,
  output logic [CHAIN_IDX_W-1:0] cur_chain_o,
  output logic [N_CHAIN-1:0]     pending_o,
  output logic                   done_pulse_o,
  output logic                   timeout_pulse_o,
  output logic [N_CHAIN-1:0]     timeout_flags_o
);

  state_t                 state, state_n;
  logic [N_CHAIN-1:0]     pend, pend_n;
  logic [N_CHAIN-1:0]     tv, tv_n;
  logic [N_CHAIN-1:0]     flags, flags_n;
  logic [CHAIN_IDX_W-1:0] cur, cur_n;
  logic [CHAIN_IDX_W-1:0] ptr, ptr_n;
  logic [PERIOD_W-1:0]    per, per_n;
  logic [TIMEOUT_W-1:0]   wd, wd_n;
  logic                   done_n, to_n;
  logic                   per_run, per_exp;
  logic                   hit, wd_exp;
  logic                   arb_found;
  logic [CHAIN_IDX_W-1:0] arb_idx;

  rr_arbiter #(.N(N_CHAIN)) u_arb (
    .req   (pend),
    .ptr   (ptr),
    .found (arb_found),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= S_IDLE;
      pend            <= '0;
      tv              <= '0;
      flags           <= '0;
      cur             <= '0;
      ptr             <= CHAIN_IDX_W'(N_CHAIN - 1);
      per             <= '0;
      wd              <= '0;
      done_pulse_o    <= 1'b0;
      timeout_pulse_o <= 1'b0;
    end else begin
      state           <= state_n;
      pend            <= pend_n;
      tv              <= tv_n;
      flags           <= flags_n;
      cur             <= cur_n;
      ptr             <= ptr_n;
      per             <= per_n;
      wd              <= wd_n;
      done_pulse_o    <= done_n;
      timeout_pulse_o <= to_n;
    end
  end

  always_comb begin
    per_run = auto_en_i && (period_i != '0);
    per_exp = per_run && (per >= period_i - PERIOD_W'(1));
    hit     = |(token_ready_i & tv);
    wd_exp  = (timeout_i != '0) && (wd >= timeout_i - TIMEOUT_W'(1));

    per_n   = (per_run && !per_exp) ? per + PERIOD_W'(1) : '0;
    pend_n  = pend | host_req_i | (per_exp ? chain_mask_i : '0);
    flags_n = flag_clr_i ? '0 : flags;
    state_n = state;
    tv_n    = tv;
    cur_n   = cur;
    ptr_n   = ptr;
    wd_n    = wd;
    done_n  = 1'b0;
    to_n    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (|pend) state_n = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          cur_n   = arb_idx;
          ptr_n   = arb_idx;
          tv_n    = N_CHAIN'(1) << arb_idx;
          wd_n    = '0;
          state_n = S_GRANT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GRANT: begin
        // Ready has priority over a watchdog expiry in the same cycle.
        if (hit) begin
          done_n  = 1'b1;
          pend_n  = pend_n & ~tv;
          tv_n    = '0;
          wd_n    = '0;
          state_n = S_GAP;
        end else if (wd_exp) begin
          to_n    = 1'b1;
          flags_n = flags_n | tv;
          pend_n  = pend_n & ~tv;
          tv_n    = '0;
          wd_n    = '0;
          state_n = S_GAP;
        end else begin
          wd_n = (timeout_i != '0) ? wd + TIMEOUT_W'(1) : '0;
        end
      end
      S_GAP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign token_valid_o   = tv;
  assign busy_o          = (state != S_IDLE);
  assign cur_chain_o     = cur;
  assign pending_o       = pend;
  assign timeout_flags_o = flags;

endmodule
